// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and tick constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;

    // Tick index of the mid start-bit sample and of the last tick in a bit
    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int last_tick(input int oversample);
        return oversample - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchronizer for the idle-high serial line
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset to the line's idle level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver with parity and framing checks
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_enable,
    input  logic                 rx_en,
    input  logic                 rx_d,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_perror,
    output logic                 rx_ferror,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID      = TW'(mid_tick(OVERSAMPLE));
    localparam logic [TW-1:0] LAST     = TW'(last_tick(OVERSAMPLE));
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state, state_nx;
    logic [TW-1:0]        tick, tick_nx;
    logic [BW-1:0]        bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 armed, armed_nx;
    logic                 perr, perr_nx;
    logic                 done;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_d),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            perr      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_perror <= 1'b0;
            rx_ferror <= 1'b0;
        end else begin
            state    <= state_nx;
            tick     <= tick_nx;
            bit_cnt  <= bit_nx;
            shreg    <= shreg_nx;
            armed    <= armed_nx;
            perr     <= perr_nx;
            rx_valid <= done;
            if (done) begin
                rx_data   <= shreg;
                rx_ferror <= ~rx_s;
                rx_perror <= perr;
            end
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        armed_nx = armed;
        perr_nx  = perr;
        done     = 1'b0;

        // Re-arm only from an idle-high line, so a held break cannot retrigger
        if (sample_enable && state == IDLE && rx_s) begin
            armed_nx = 1'b1;
        end

        if (!rx_en) begin
            state_nx = IDLE;
            tick_nx  = '0;
        end else if (sample_enable) begin
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        armed_nx = 1'b0;
                        state_nx = START;
                        tick_nx  = '0;
                    end
                end
                START: begin
                    if (tick == MID) begin
                        tick_nx  = '0;
                        bit_nx   = '0;
                        perr_nx  = 1'b0;
                        state_nx = rx_s ? IDLE : DATA;
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick == LAST) begin
                        shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
                        tick_nx  = '0;
                        bit_nx   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick == LAST) begin
                        perr_nx  = (^shreg) ^ rx_s ^ (PARITY_ODD != 0);
                        tick_nx  = '0;
                        state_nx = STOP;
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick == LAST) begin
                        done     = 1'b1;
                        tick_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    tick_nx  = '0;
                end
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_enable = 1'b0;
    logic       rx_en = 1'b1;
    logic       rx_d = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perror;
    logic       rx_ferror;
    logic       rx_busy;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    exp_t q[$];
    int   vtimes[$];
    int   errors = 0;
    int   checks = 0;
    int   valid_cnt = 0;
    int   cyc = 0;

    uart_receiver #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_enable (sample_enable),
        .rx_en         (rx_en),
        .rx_d          (rx_d),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_perror     (rx_perror),
        .rx_ferror     (rx_ferror),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sample_enable = 1'b1;
            @(negedge clk);
            sample_enable = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rx_valid pops one expected frame
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            valid_cnt++;
            vtimes.push_back(cyc);
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                chk("rx_perror", {31'd0, rx_perror}, {31'd0, e.pe});
                chk("rx_ferror", {31'd0, rx_ferror}, {31'd0, e.fe});
                chk("busy_falls_with_valid", {31'd0, rx_busy}, 32'd0);
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", q.size(), 32'd0);
    endtask

    // Drives one frame; abort_at >= 0 aborts mid-way through that bit index
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int abort_at, input bit use_rst);
        logic bits [11];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = p;
        bits[10] = s;
        for (int i = 0; i < 11; i++) begin
            rx_d = bits[i];
            if (i == abort_at) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                if (use_rst) rst = 1'b1;
                else rx_en = 1'b0;
                @(negedge clk);
                chk("abort_busy", {31'd0, rx_busy}, 32'd0);
                chk("abort_valid", {31'd0, rx_valid}, 32'd0);
                if (use_rst) begin
                    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
                    chk("rst_perror", {31'd0, rx_perror}, 32'd0);
                    chk("rst_ferror", {31'd0, rx_ferror}, 32'd0);
                end
                rst  = 1'b0;
                rx_d = 1'b1;
                repeat (BIT_CLKS * 12) @(negedge clk);
                rx_en = 1'b1;
                repeat (BIT_CLKS * 2) @(negedge clk);
                return;
            end
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    vec_t vecs [5];

    initial begin
        int v0;
        bit saw;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b1};

        repeat (5) @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_perror", {31'd0, rx_perror}, 32'd0);
        chk("reset_ferror", {31'd0, rx_ferror}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (BIT_CLKS * 2) @(negedge clk);

        foreach (vecs[k]) begin
            push_exp(vecs[k].data, vecs[k].exp_pe, vecs[k].exp_fe);
            send_frame(vecs[k].data, vecs[k].par, vecs[k].stop, -1, 1'b0);
            rx_d = 1'b1;
            wait_drain();
            repeat (100) @(negedge clk);
            chk("hold_perror", {31'd0, rx_perror}, {31'd0, vecs[k].exp_pe});
            chk("hold_ferror", {31'd0, rx_ferror}, {31'd0, vecs[k].exp_fe});
        end

        // Framing error followed by a long break: exactly one delivery
        v0 = valid_cnt;
        push_exp(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, -1, 1'b0);
        repeat (20 * BIT_CLKS) @(negedge clk);
        chk("break_valid_count", valid_cnt - v0, 32'd1);
        rx_d = 1'b1;
        repeat (BIT_CLKS * 2) @(negedge clk);
        push_exp(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, -1, 1'b0);
        wait_drain();
        repeat (BIT_CLKS) @(negedge clk);

        // rx_en dropped during data bit 4: no delivery, data retained
        v0 = valid_cnt;
        send_frame(8'h5A, 1'b0, 1'b1, 5, 1'b0);
        chk("en_abort_no_valid", valid_cnt - v0, 32'd0);
        chk("en_abort_data_kept", {24'd0, rx_data}, 32'h81);

        // rst during data bit 2
        v0 = valid_cnt;
        send_frame(8'h66, 1'b0, 1'b1, 3, 1'b1);
        chk("rst_abort_no_valid", valid_cnt - v0, 32'd0);

        // Start-bit glitch of 3 ticks
        v0 = valid_cnt;
        saw = 1'b0;
        rx_d = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rx_busy) saw = 1'b1;
        end
        rx_d = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (rx_busy) saw = 1'b1;
        end
        chk("glitch_busy_seen", {31'd0, saw}, 32'd1);
        chk("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        chk("glitch_no_valid", valid_cnt - v0, 32'd0);
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, -1, 1'b0);
        wait_drain();
        repeat (BIT_CLKS) @(negedge clk);

        // Back-to-back frames with no idle gap
        vtimes.delete();
        push_exp(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, -1, 1'b0);
        push_exp(8'h80, 1'b0, 1'b0);
        send_frame(8'h80, 1'b1, 1'b1, -1, 1'b0);
        push_exp(8'hFE, 1'b0, 1'b0);
        send_frame(8'hFE, 1'b1, 1'b1, -1, 1'b0);
        wait_drain();
        chk("b2b_count", vtimes.size(), 32'd3);
        if (vtimes.size() == 3) begin
            chk("b2b_spacing_1", vtimes[1] - vtimes[0], 11 * BIT_CLKS);
            chk("b2b_spacing_2", vtimes[2] - vtimes[1], 11 * BIT_CLKS);
        end

        repeat (BIT_CLKS) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART serial receiver that sits directly downstream of the baud-rate generator. It consumes the generator's 16x-oversampling strobe, detects and validates start bits, and samples each bit at mid-period, LSB first. It checks optional parity and the stop bit, then presents one received byte per frame to the host side with a one-cycle valid pulse and error flags.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVERSAMPLE, 16, sample_enable pulses per bit period (power of 2, >=8)
PARITY_EN, 1, 1 = frame carries a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
sample_enable  in  1  one-clk strobe at OVERSAMPLE x baud from the baud generator
rx_en  in  1  receiver enable
rx_d  in  1  serial line, asynchronous, idle high
rx_data  out  DATA_BITS  last received word
rx_valid  out  1  one-clk pulse: rx_data and flags updated
rx_perror  out  1  parity error on last frame
rx_ferror  out  1  framing error (stop bit sampled 0) on last frame
rx_busy  out  1  high while a frame is in progress

Behaviour:
- rx_d passes through a 2-FF synchronizer. Both FFs reset to 1. All sampling uses the synchronized value rx_s.
- State, bit counter and tick counter (log2(OVERSAMPLE) bits) advance only on clocks with sample_enable=1. Outputs update on clk.
- Reset values: state IDLE, rx_data 0, rx_valid 0, rx_perror 0, rx_ferror 0, rx_busy 0, armed 0, counters 0.
- armed flag: set on any tick with rx_s=1; cleared on start detect. A start is accepted only when armed, so a held-low line (break) never retriggers.
- IDLE: on a tick with rx_en=1, armed=1 and rx_s=0, go to START with tick=0.
- START: tick++ each strobe. At tick==OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: tick=0, bit=0, go to DATA.
  - rx_s=1: glitch; return to IDLE with no output change.
- DATA: at tick==OVERSAMPLE-1, shift rx_s in LSB first, tick=0, bit++. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: at tick==OVERSAMPLE-1, perr_next = (XOR of data bits ^ rx_s ^ PARITY_ODD); go to STOP.
- STOP: at tick==OVERSAMPLE-1:
  - Load rx_data from the shift register.
  - Set rx_ferror = ~rx_s and rx_perror = perr_next (0 if no parity).
  - Pulse rx_valid on the next clk.
  - Go to IDLE.
  - Latency: rx_valid is high exactly 1 clk after the strobe that samples mid-stop-bit.
- A frame with errors still produces rx_valid; data is delivered with flags set.
- rx_perror and rx_ferror hold until the next rx_valid.
- rx_busy = (state != IDLE).
- rx_en=0 in any state: on the next clk go to IDLE, tick=0. The frame is abandoned with no rx_valid; rx_data and flags retain their values.
- rst asserted mid-frame: on the next clk all registers take reset values; any in-flight frame is lost.
- sample_enable held high continuously: legal; the receiver simply runs at clk/OVERSAMPLE baud.
- Bit timing tolerates up to +/-3% baud mismatch via mid-bit sampling. No majority vote.

Decomposition:
- Shared header uart_pkg (include file) holds:
  - state encodings IDLE/START/DATA/PARITY/STOP (3-bit localparams)
  - default OVERSAMPLE
  - MID_TICK = OVERSAMPLE/2-1
  - LAST_TICK = OVERSAMPLE-1
- The transmitter reuses the same header.
- One sub-module is natural: uart_rx_sync, the 2-FF synchronizer with reset-to-1.

Test Plan:
- Bench setup: sample_enable every 4 clks; bit period 64 clks; even parity.
- Clean frame: send 0xA5, parity 0, stop 1 -> rx_valid one clk, rx_data=0xA5, rx_perror=0, rx_ferror=0, rx_busy falls with rx_valid.
- Bad parity: send 0x3C with parity bit 1 -> rx_data=0x3C, rx_perror=1, rx_ferror=0. A following clean 0x00 frame clears rx_perror.
- Framing/break: send 0x55 with stop bit 0, then hold rx_d=0 for 20 bit times -> one rx_valid with rx_ferror=1, no further rx_valid. After rx_d returns high, a 0x81 frame is received correctly.
- Start glitch: pull rx_d low for 3 ticks only -> rx_busy pulses, then returns to 0; no rx_valid; a subsequent 0xFF frame is received.
- Abort: drop rx_en during data bit 4 of a frame, and separately assert rst during data bit 2 -> no rx_valid, rx_busy=0 next clk. After rst, all outputs are 0; after rx_en abort, rx_data is unchanged.
- Back-to-back: send 0x01, 0x80, 0xFE with no idle gap -> three rx_valid pulses 11 bit periods apart, with data in order.
